// File: rtl/fifo_16x6_if.sv
// Push/pop handshake bundle between a producer/consumer and the 16x6 FIFO.
interface fifo_16x6_if #(
    parameter int unsigned DATA_WIDTH = 6
);
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] Fifo_Data_in;
    logic [DATA_WIDTH-1:0] Fifo_Data_out;
    logic                  Fifo_Empty;
    logic                  Fifo_Full;
    logic                  Fifo_Almost_Empty;
    logic                  Pausa;
    logic                  Fifo_Error;

    // Requester side: issues push/pop and watches the status flags.
    modport master (
        output push,
        output pop,
        output Fifo_Data_in,
        input  Fifo_Data_out,
        input  Fifo_Empty,
        input  Fifo_Full,
        input  Fifo_Almost_Empty,
        input  Pausa,
        input  Fifo_Error
    );

    // Responder side: the FIFO itself.
    modport slave (
        input  push,
        input  pop,
        input  Fifo_Data_in,
        output Fifo_Data_out,
        output Fifo_Empty,
        output Fifo_Full,
        output Fifo_Almost_Empty,
        output Pausa,
        output Fifo_Error
    );
endinterface

// File: rtl/fifo_16x6.sv
// 16-entry x 6-bit synchronous FIFO with registered read data, occupancy
// flags decoded from the registered count, and a one-cycle error pulse on
// overflow/underflow.
module fifo_16x6 #(
    parameter int unsigned DATA_WIDTH   = 6,
    parameter int unsigned ADDR_WIDTH   = 4,
    parameter int unsigned ALMOST_FULL  = 1,
    parameter int unsigned ALMOST_EMPTY = 3
) (
    input  logic         clk,
    input  logic         reset_L,
    fifo_16x6_if.slave   bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned CNT_W = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q,  count_d;
    logic [DATA_WIDTH-1:0] data_q,   data_d;
    logic                  err_q,    err_d;

    logic empty_c;
    logic full_c;
    logic push_ok_c;
    logic pop_ok_c;

    assign empty_c = (count_q == CNT_W'(0));
    assign full_c  = (count_q == CNT_W'(DEPTH));

    // A full FIFO still takes a write when a pop frees a slot on the same edge;
    // an empty FIFO never bypasses the incoming word to the read port.
    assign push_ok_c = bus.push && (!full_c || bus.pop);
    assign pop_ok_c  = bus.pop && !empty_c;

    // Next-state for pointers, count, read data and error pulse.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        data_d   = data_q;
        err_d    = 1'b0;

        if (push_ok_c) begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        end
        if (pop_ok_c) begin
            rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
            data_d   = mem[rd_ptr_q];
        end

        case ({push_ok_c, pop_ok_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        err_d = (bus.push && !push_ok_c) || (bus.pop && !pop_ok_c);
    end

    // Control state; reset discards all stored words at once.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            data_q   <= data_d;
            err_q    <= err_d;
        end
    end

    // Storage array; contents are don't-care after reset so it has none.
    always_ff @(posedge clk) begin
        if (push_ok_c) begin
            mem[wr_ptr_q] <= bus.Fifo_Data_in;
        end
    end

    assign bus.Fifo_Data_out     = data_q;
    assign bus.Fifo_Error        = err_q;
    assign bus.Fifo_Empty        = empty_c;
    assign bus.Fifo_Full         = full_c;
    assign bus.Fifo_Almost_Empty = !empty_c && (count_q <= CNT_W'(ALMOST_EMPTY));
    assign bus.Pausa             = (count_q >= CNT_W'(DEPTH - ALMOST_FULL));
endmodule

// File: tb/tb_fifo_16x6.sv
// Scoreboard bench for fifo_16x6: each stimulus cycle queues the expected
// outputs; a negedge monitor pops and compares them against the DUT.
module tb_fifo_16x6;
    typedef struct {
        logic [5:0] dout;
        logic       empty;
        logic       full;
        logic       ae;
        logic       pausa;
        logic       err;
    } exp_t;

    logic clk;
    logic reset_L;

    fifo_16x6_if #(.DATA_WIDTH(6)) bus ();

    fifo_16x6 dut (
        .clk     (clk),
        .reset_L (reset_L),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb_q[$];

    // Reference state tracked by the bench.
    logic [5:0] model_q[$];
    logic [5:0] model_out;
    logic       model_err;

    logic [5:0] fill_vec [16];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t make_exp();
        exp_t e;
        int   c;
        c       = model_q.size();
        e.dout  = model_out;
        e.empty = (c == 0);
        e.full  = (c == 16);
        e.ae    = (c >= 1) && (c <= 3);
        e.pausa = (c >= 15);
        e.err   = model_err;
        return e;
    endfunction

    // Monitor: one expected record per falling edge.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk("Fifo_Data_out",     int'(bus.Fifo_Data_out),     int'(e.dout));
            chk("Fifo_Empty",        int'(bus.Fifo_Empty),        int'(e.empty));
            chk("Fifo_Full",         int'(bus.Fifo_Full),         int'(e.full));
            chk("Fifo_Almost_Empty", int'(bus.Fifo_Almost_Empty), int'(e.ae));
            chk("Pausa",             int'(bus.Pausa),             int'(e.pausa));
            chk("Fifo_Error",        int'(bus.Fifo_Error),        int'(e.err));
        end
    end

    // One clock of stimulus; expected result queued right after the edge.
    task automatic step(input logic p, input logic q, input logic [5:0] d);
        bit full, pa, pu;
        bus.push         = p;
        bus.pop          = q;
        bus.Fifo_Data_in = d;
        @(posedge clk);
        #1;
        full = (model_q.size() == 16);
        pa   = q && (model_q.size() > 0);
        pu   = p && (!full || q);
        model_err = (p && !pu) || (q && !pa);
        if (pa) model_out = model_q.pop_front();
        if (pu) model_q.push_back(d);
        sb_q.push_back(make_exp());
        bus.push = 1'b0;
        bus.pop  = 1'b0;
    endtask

    task automatic model_reset();
        model_q.delete();
        model_out = 6'h00;
        model_err = 1'b0;
    endtask

    task automatic fill16();
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, fill_vec[i]);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 6'h00);
    endtask

    // Watchdog so a stuck run still terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        fill_vec = '{6'h11, 6'h16, 6'h30, 6'h1C, 6'h1A, 6'h1B, 6'h1D, 6'h1E,
                     6'h1F, 6'h12, 6'h13, 6'h14, 6'h15, 6'h17, 6'h18, 6'h19};
        bus.push         = 1'b0;
        bus.pop          = 1'b0;
        bus.Fifo_Data_in = 6'h00;
        reset_L          = 1'b0;
        model_reset();

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 reset_L = 1'b1;
        sb_q.push_back(make_exp());
        @(negedge clk);
        #1;

        // Fill then drain, returning the same order.
        fill16();
        drain(16);
        // Underflow on empty: error pulse, output holds 0x19.
        drain(1);
        step(1'b0, 1'b0, 6'h00);

        // Overflow: 0x01 dropped, then drain 16.
        fill16();
        step(1'b1, 1'b0, 6'h01);
        step(1'b0, 1'b0, 6'h00);
        drain(16);
        step(1'b0, 1'b0, 6'h00);

        // Simultaneous push/pop around empty.
        step(1'b1, 1'b0, 6'h1A);
        step(1'b1, 1'b1, 6'h1B);
        step(1'b1, 1'b1, 6'h1C);
        step(1'b0, 1'b1, 6'h00);
        step(1'b0, 1'b1, 6'h00);
        // Push+pop on empty: push taken, pop rejected, no bypass.
        step(1'b1, 1'b1, 6'h2C);
        drain(1);
        step(1'b0, 1'b0, 6'h00);

        // Push+pop at full: no error, stays full.
        fill16();
        step(1'b1, 1'b1, 6'h2A);
        step(1'b0, 1'b0, 6'h00);
        drain(16);

        // Mid-operation asynchronous reset.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 6'(i + 3));
        @(negedge clk);
        #2 reset_L = 1'b0;
        #1;
        model_reset();
        sb_q.push_back(make_exp());
        @(negedge clk);
        #1 reset_L = 1'b1;
        drain(1);
        step(1'b0, 1'b0, 6'h00);

        @(negedge clk);
        #1;
        chk("scoreboard_drained", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
